nmr_delay_t1_timer: RTL and testbench

- Consumes the 32-bit T1 delay word from the NMR parameter output register and turns it into a timed gate for the inversion-recovery sequence.
- On a start strobe from the sequencer, latches the delay and holds `delay_active` high for exactly that many clocks.
- Then issues a one-cycle `done` pulse so the sequencer can fire the next pulse.
- Supports abort, status readback and zero-length delays.

---
 rtl/nmr_delay_t1_timer.sv | 174 +++++++++++++++++
 tb/tb_nmr_delay_t1_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_delay_t1_timer.sv
// ---------------------------------------------------------------------------
// nmr_delay_t1_timer
//
// Converts the T1 delay word from the NMR parameter register into a timed gate
// for the inversion-recovery sequence. An accepted start latches the delay and
// holds delay_active high for exactly D ticks. A one-cycle done pulse then lets
// the sequencer fire the next RF pulse. Abort cancels a running delay and pulses
// aborted. A zero delay goes straight to done without opening the gate.
//
// Ports
//   clk           system clock (shared with the parameter register)
//   reset_n       asynchronous active-low reset
//   delay_cycles  T1 delay in ticks, sampled only on an accepted start
//   start         one-cycle start strobe, ignored while busy
//   abort         cancels a running delay; beats start in IDLE
//   busy          high while the timer is not IDLE
//   delay_active  T1 gate, high while in RUN
//   done          one-cycle pulse on normal completion
//   aborted       one-cycle pulse after a running delay is cancelled
//   remaining     live down-counter in RUN, 0 otherwise
//
// Optional build macro: NMR_DELAY_T1_PRESCALE_EN
//   When it is defined, a 16-bit prescaler produces one count tick every
//   PRESCALE clocks, so the gate lasts D*PRESCALE clocks. PRESCALE=1 gives the
//   same timing as a build without the macro. When the macro is undefined,
//   every RUN clock is a tick and no prescaler logic exists.
// ---------------------------------------------------------------------------
module nmr_delay_t1_timer #(
  parameter int DELAY_WIDTH = 32,
  parameter int PRESCALE    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DELAY_WIDTH-1:0] delay_cycles,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   delay_active,
  output logic                   done,
  output logic                   aborted,
  output logic [DELAY_WIDTH-1:0] remaining
);

  // A PRESCALE outside the 16-bit prescaler range is rejected at elaboration.
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("nmr_delay_t1_timer: PRESCALE must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DELAY_WIDTH-1:0] CNT_ONE  = DELAY_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] CNT_ZERO = '0;

  state_e                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] count_q, count_d;
  logic                   aborted_d;
  logic                   tick;

`ifdef NMR_DELAY_T1_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;

  // The tick fires on the last clock of each PRESCALE-long window. The
  // prescaler is cleared on start and abort, so every delay starts with a
  // full window.
  assign tick = (pre_q == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    aborted_d = 1'b0;
`ifdef NMR_DELAY_T1_PRESCALE_EN
    pre_d     = pre_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Abort takes priority, so start together with abort is a no-op.
        if (start && !abort) begin
`ifdef NMR_DELAY_T1_PRESCALE_EN
          pre_d = 16'd0;
`endif
          if (delay_cycles != CNT_ZERO) begin
            state_d = S_RUN;
            count_d = delay_cycles;
          end else begin
            // A zero-length delay never opens the gate.
            state_d = S_DONE;
            count_d = CNT_ZERO;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          count_d   = CNT_ZERO;
          aborted_d = 1'b1;
`ifdef NMR_DELAY_T1_PRESCALE_EN
          pre_d     = 16'd0;
`endif
        end else if (tick) begin
`ifdef NMR_DELAY_T1_PRESCALE_EN
          pre_d = 16'd0;
`endif
          // The exit happens on the tick that would take the count from 1
          // to 0, so the counter never wraps even for the maximum D.
          if (count_q == CNT_ONE) begin
            state_d = S_DONE;
            count_d = CNT_ZERO;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end else begin
`ifdef NMR_DELAY_T1_PRESCALE_EN
          pre_d = pre_q + 16'd1;
`endif
        end
      end

      S_DONE: begin
        // Abort is ignored here, so the completion pulse is always delivered.
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end

      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // State register. Each output is decoded from the next state, so the
  // outputs change on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= CNT_ZERO;
      busy         <= 1'b0;
      delay_active <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      remaining    <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      busy         <= (state_d != S_IDLE);
      delay_active <= (state_d == S_RUN);
      done         <= (state_d == S_DONE);
      aborted      <= aborted_d;
      remaining    <= (state_d == S_RUN) ? count_d : CNT_ZERO;
    end
  end

`ifdef NMR_DELAY_T1_PRESCALE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= 16'd0;
    end else begin
      pre_q <= pre_d;
    end
  end
`endif

endmodule

// File: tb/tb_nmr_delay_t1_timer.sv
module tb_nmr_delay_t1_timer;

`ifdef NMR_DELAY_T1_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] delay_cycles;
  logic        start, abort;
  logic        busy, delay_active, done, aborted;
  logic [31:0] remaining;

  nmr_delay_t1_timer #(.DELAY_WIDTH(32), .PRESCALE(PS)) dut (
    .clk(clk), .reset_n(reset_n), .delay_cycles(delay_cycles),
    .start(start), .abort(abort), .busy(busy), .delay_active(delay_active),
    .done(done), .aborted(aborted), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model. A transaction is described by the edge that accepted it
  // (m_s), its delay (m_D) and the edge that aborted it (m_ab, -1 if none).
  // Expected outputs for any cycle follow from arithmetic on these values.
  longint cyc  = 0;
  bit     m_have = 0;
  longint m_s = 0, m_D = 0, m_ab = -1;
  logic [35:0] exp_v, obs_v;

  // 0 idle, 1 gate, 2 done, for the cycle that follows edge t
  function automatic int phase(longint t);
    longint rel = t - m_s + 1;
    if (!m_have) return 0;
    if (m_ab >= 0 && t >= m_ab) return 0;
    if (m_D == 0) return (rel == 1) ? 2 : 0;
    if (rel >= 1 && rel <= m_D * PS) return 1;
    if (rel == m_D * PS + 1) return 2;
    return 0;
  endfunction

  // Apply one cycle of inputs, advance the model and capture expected and observed outputs.
  task automatic step(input logic st, input logic ab, input logic [31:0] dl);
    int ph;
    start = st; abort = ab; delay_cycles = dl;
    @(posedge clk);
    cyc++;
    ph = phase(cyc - 1);
    if (ph == 0 && st && !ab) begin
      m_have = 1; m_s = cyc; m_D = longint'(dl); m_ab = -1;
    end else if (ph == 1 && ab) begin
      m_ab = cyc;
    end
    #1;
    ph = phase(cyc);
    exp_v = {ph != 0, ph == 1, ph == 2, m_ab == cyc,
             (ph == 1) ? 32'(m_D - (cyc - m_s) / PS) : 32'h0};
    obs_v = {busy, delay_active, done, aborted, remaining};
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; abort = 1'b0; delay_cycles = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, delay_active, done, aborted, remaining} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset got=%h exp=0", {busy, delay_active, done, aborted, remaining});
    end
    start = 1'b0;
    reset_n = 1'b1;
    m_have = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      vectors++;
      if (obs_v !== 36'h0) begin
        miscompares++; $display("FAIL reset_idle cyc=%0d got=%h exp=0", cyc, obs_v);
      end
    end
  endtask

  task automatic test_basic();
    int gate = 0, done_at = -1;
    for (int i = 1; i <= 5 * PS + 4; i++) begin
      if (i == 1) step(1, 0, 5); else step(0, 0, 0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (delay_active) gate++;
      if (delay_active && remaining !== 32'(5 - (i - 1) / PS)) begin
        miscompares++; $display("FAIL basic_remaining i=%0d got=%0d", i, remaining);
      end
      if (done) done_at = i;
    end
    vectors++;
    if (gate != 5 * PS || done_at != 5 * PS + 1) begin
      miscompares++;
      $display("FAIL basic_len gate=%0d done_at=%0d exp %0d/%0d", gate, done_at, 5 * PS, 5 * PS + 1);
    end
  endtask

  task automatic test_zero();
    int busy_n = 0, gate = 0, done_at = -1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) step(1, 0, 0); else step(0, 0, 0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      busy_n += int'(busy); gate += int'(delay_active);
      if (done) done_at = i;
    end
    vectors++;
    if (busy_n != 1 || gate != 0 || done_at != 1) begin
      miscompares++;
      $display("FAIL zero_len busy=%0d gate=%0d done_at=%0d exp 1/0/1", busy_n, gate, done_at);
    end
  endtask

  task automatic test_abort();
    int done_n = 0;
    step(1, 0, 100);
    for (int i = 0; i < 39; i++) begin
      step(0, 0, 0);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
    step(0, 1, 0);
    vectors++;
    if (obs_v !== exp_v || {busy, delay_active, done, aborted, remaining} !== {4'b0001, 32'h0}) begin
      miscompares++; $display("FAIL abort_pulse cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    end
    step(1, 0, 3);
    vectors++;
    if (obs_v !== exp_v || busy !== 1'b1 || aborted !== 1'b0) begin
      miscompares++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    end
    for (int i = 0; i < 3 * PS + 2; i++) begin
      step(0, 0, 0);
      done_n += int'(done);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL abort_tail cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
    vectors++;
    if (done_n != 1) begin
      miscompares++; $display("FAIL abort_tail_done got=%0d exp=1", done_n);
    end
  endtask

  task automatic test_back_to_back();
    int gate = 0, done_n = 0;
    for (int i = 1; i <= 10 * PS + 4; i++) begin
      if (i == 1) step(1, 0, 10);
      else if (i == 2) step(1, 0, 3);
      else step(0, 0, 3);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      gate += int'(delay_active); done_n += int'(done);
    end
    vectors++;
    if (gate != 10 * PS || done_n != 1) begin
      miscompares++; $display("FAIL b2b_len gate=%0d done=%0d exp %0d/1", gate, done_n, 10 * PS);
    end
  endtask

  task automatic test_start_abort_idle();
    for (int i = 0; i < 3; i++) begin
      step(i == 0, i == 0, 9);
      vectors++;
      if (obs_v !== 36'h0 || exp_v !== 36'h0) begin
        miscompares++; $display("FAIL start_abort cyc=%0d got=%h exp=0", cyc, obs_v);
      end
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 0, 50);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    vectors++;
    if (delay_active !== 1'b1) begin
      miscompares++; $display("FAIL midrun_pre got=%b exp=1", delay_active);
    end
    reset_n = 1'b0;
    #1;
    m_have = 0;
    vectors++;
    if ({busy, delay_active, remaining} !== 34'h0) begin
      miscompares++; $display("FAIL midrun_async busy=%b gate=%b rem=%0d exp 0", busy, delay_active, remaining);
    end
    #2 reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0);
      vectors++;
      if (obs_v !== 36'h0) begin
        miscompares++; $display("FAIL midrun_after cyc=%0d got=%h exp=0", cyc, obs_v);
      end
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 6; i++) begin
      step(i == 0, i == 5, 32'hFFFF_FFFF);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL max cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
    step(0, 0, 0);
    vectors++;
    if (obs_v !== exp_v) begin
      miscompares++; $display("FAIL max_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) == 0, ($urandom % 24) == 0, 32'($urandom % 12));
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_midrun();
    test_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
